mult_share_arb: RTL

- Shares one instance of the team's combinational 4x4 `multiplier` between two requesters.
- Arbitrates between them, latches the winner's operands and waits a programmable settle time.
- Captures the 8-bit product and returns it with a one-cycle acknowledge to the winning requester.
- Sits between requester logic and the multiplier datapath, so the multiplier is never driven by two sources at once.

---
 rtl/mult_share_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arb.sv
// Two-requester arbiter sharing one combinational 4x4 multiplier; registered product/ack.
// Define MULT_ARB_RR_EN for round-robin tie-breaking, otherwise req0 has fixed priority.

module multiplier (
   input  logic a3, a2, a1, a0,
   input  logic b3, b2, b1, b0,
   output logic p7, p6, p5, p4, p3, p2, p1, p0
);
   logic [7:0] p_c;

   assign p_c = {4'b0000, a3, a2, a1, a0} * {4'b0000, b3, b2, b1, b0};
   assign {p7, p6, p5, p4, p3, p2, p1, p0} = p_c;
endmodule

module mult_share_arb #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [3:0] a0_in,
   input  logic [3:0] b0_in,
   input  logic       req1,
   input  logic [3:0] a1_in,
   input  logic [3:0] b1_in,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] prod,
   output logic       prod_id,
   output logic       prod_valid,
   output logic       busy
);
   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt_q, gnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic [PROD_W-1:0] prod_q, prod_d;
   logic              prod_id_q, prod_id_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              prod_valid_q, prod_valid_d;
   logic              busy_q, busy_d;
   logic [PROD_W-1:0] mul_p;
   logic              win_c;

   // Winner among active requests; only consulted in IDLE when at least one is high.
`ifdef MULT_ARB_RR_EN
   assign win_c = (req0 && req1) ? ~last_gnt_q : req1;
`else
   assign win_c = ~req0;
`endif

   multiplier u_mul (
      .a3(op_a_q[3]), .a2(op_a_q[2]), .a1(op_a_q[1]), .a0(op_a_q[0]),
      .b3(op_b_q[3]), .b2(op_b_q[2]), .b1(op_b_q[1]), .b0(op_b_q[0]),
      .p7(mul_p[7]), .p6(mul_p[6]), .p5(mul_p[5]), .p4(mul_p[4]),
      .p3(mul_p[3]), .p2(mul_p[2]), .p1(mul_p[1]), .p0(mul_p[0])
   );

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      last_gnt_d   = last_gnt_q;
      prod_d       = prod_q;
      prod_id_d    = prod_id_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      prod_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d   = win_c;
               op_a_d  = win_c ? a1_in : a0_in;
               op_b_d  = win_c ? b1_in : b0_in;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt_q == CNT_LAST) begin
               prod_d       = mul_p;
               prod_id_d    = gnt_q;
               ack0_d       = ~gnt_q;
               ack1_d       = gnt_q;
               prod_valid_d = 1'b1;
               last_gnt_d   = gnt_q;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         cnt_q        <= '0;
         gnt_q        <= 1'b0;
         last_gnt_q   <= 1'b1;
         prod_q       <= '0;
         prod_id_q    <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         prod_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         last_gnt_q   <= last_gnt_d;
         prod_q       <= prod_d;
         prod_id_q    <= prod_id_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         prod_valid_q <= prod_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign prod       = prod_q;
   assign prod_id    = prod_id_q;
   assign prod_valid = prod_valid_q;
   assign busy       = busy_q;
endmodule
